// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// Runs mult/multu/div/divu with a fixed multi-cycle latency and handles mthi/mtlo.
// The result is computed at the start edge and held until the countdown expires.
// Optional feature macro: MDU_MADD_EN enables madd (op 7) and maddu (op 8).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic          busy_reg;
  logic [CW-1:0] cnt_reg;
  logic [63:0]   tmp_reg;
  logic          tmp_wr_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;

  logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_madd, is_maddu;
  logic is_divide;

  assign is_mult   = (E_MDUOp == OP_MULT);
  assign is_multu  = (E_MDUOp == OP_MULTU);
  assign is_div    = (E_MDUOp == OP_DIV);
  assign is_divu   = (E_MDUOp == OP_DIVU);
  assign is_mthi   = (E_MDUOp == OP_MTHI);
  assign is_mtlo   = (E_MDUOp == OP_MTLO);
`ifdef MDU_MADD_EN
  assign is_madd   = (E_MDUOp == OP_MADD);
  assign is_maddu  = (E_MDUOp == OP_MADDU);
`else
  // Without the accumulate feature ops 7/8 behave exactly like "none".
  assign is_madd   = 1'b0;
  assign is_maddu  = 1'b0;
`endif
  assign is_divide = is_div | is_divu;

  // Raw decode; the hazard unit qualifies it with E_Busy.
  assign E_Start = is_mult | is_multu | is_divide | is_madd | is_maddu;

  // 64-bit products; the signed one is formed from sign-extended operands so the
  // low 64 bits are the exact two's-complement product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Division on magnitudes, then sign fix-up: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000 / -1 falls out naturally as 0x80000000.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
  assign a_neg   = is_div & E_A[31];
  assign b_neg   = is_div & E_B[31];
  assign b_zero  = (E_B == 32'd0);
  assign a_mag   = a_neg ? (32'd0 - E_A) : E_A;
  assign b_mag   = b_neg ? (32'd0 - E_B) : E_B;
  assign div_den = b_zero ? 32'd1 : b_mag;
  assign q_mag   = a_mag / div_den;
  assign r_mag   = a_mag % div_den;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [63:0]   result_next;
  logic [CW-1:0] load_next;
  logic          wr_next;

  // Select the pending result, latency and write-enable for an op starting this cycle.
  always_comb begin
    result_next = 64'd0;
    load_next   = is_divide ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    wr_next     = !(is_divide && b_zero);
    if (is_mult)
      result_next = prod_s;
    else if (is_multu)
      result_next = prod_u;
    else if (is_divide)
      result_next = {rem, quot};
`ifdef MDU_MADD_EN
    else if (is_madd)
      result_next = {hi_reg, lo_reg} + prod_s;
    else if (is_maddu)
      result_next = {hi_reg, lo_reg} + prod_u;
`endif
  end

  // Start, countdown, completion write-back and mthi/mtlo updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      tmp_reg    <= 64'd0;
      tmp_wr_reg <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
    end else if (busy_reg) begin
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
        if (tmp_wr_reg) begin
          hi_reg <= tmp_reg[63:32];
          lo_reg <= tmp_reg[31:0];
        end
      end
    end else if (E_Start) begin
      tmp_reg    <= result_next;
      tmp_wr_reg <= wr_next;
      cnt_reg    <= load_next;
      busy_reg   <= 1'b1;
    end else if (is_mthi) begin
      hi_reg <= E_A;
    end else if (is_mtlo) begin
      lo_reg <= E_A;
    end
  end

`ifndef SYNTHESIS
  // Report MD instructions that reached this unit while it was still busy.
  always @(posedge clk) begin
    if (!reset && busy_reg && (E_Start || is_mthi || is_mtlo))
      $display("e_mdu warning: op %0d issued while busy, ignored", E_MDUOp);
  end
`endif

  assign E_Busy = busy_reg;
  assign E_HI   = hi_reg;
  assign E_LO   = lo_reg;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized scoreboard bench for e_mdu.
// The driver issues one op per cycle and pushes the expected post-edge state; a
// monitor pops and compares at each falling edge. Honors MDU_MADD_EN like the DUT.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A, E_B;
  logic        E_Start, E_Busy;
  logic [31:0] E_HI, E_LO;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
    .E_Start(E_Start), .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          due;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  // Reference state: visible HI/LO plus one pending result with its landing edge.
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend_val;
  bit          pend, pend_wr;
  int          apply_edge, busy_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0; pend_wr = 1'b0;
    pend_val = 64'd0; apply_edge = 0; busy_end = 0;
  endtask

  // Architectural result of a start op, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sbv, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      4'd1: return sa * sbv;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sbv; r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      4'd7: return acc + sa * sbv;
      4'd8: return acc + ua * ub;
      default: return 64'd0;
    endcase
  endfunction

  // Drive one op for the next rising edge, predict the state after it, wait a cycle.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   p, n;
    bit   start_op, is_dv;
    exp_t e;
    E_MDUOp = op; E_A = a; E_B = b;
    start_op = (op inside {[4'd1:4'd4]}) || (MADD_ON && (op == 4'd7 || op == 4'd8));
    is_dv = (op == 4'd3 || op == 4'd4);
    #1;
    chk("start_decode", 32'(E_Start), 32'(start_op));
    p = edge_cnt + 1;
    if (pend && p >= apply_edge) begin
      if (pend_wr) {m_hi, m_lo} = pend_val;
      pend = 1'b0;
    end
    if (p > busy_end) begin
      if (start_op) begin
        n = is_dv ? DC : MC;
        pend_val = ref_result(op, a, b, {m_hi, m_lo});
        pend_wr = !(is_dv && b == 32'd0);
        pend = 1'b1; apply_edge = p + n; busy_end = p + n;
        $display("txn edge=%0d op=%0d a=%08h b=%08h result=%016h", p, op, a, b, pend_val);
      end else if (op == 4'd5) m_hi = a;
      else if (op == 4'd6) m_lo = a;
    end
    e.due = p; e.busy = (p < busy_end); e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset between edges, confirm it acts at once, release at the next falling edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(E_Busy), 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    sb.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: compare every expected post-edge state once its edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("busy@%0d", e.due), 32'(E_Busy), 32'(e.busy));
      chk($sformatf("hi@%0d", e.due), E_HI, e.hi);
      chk($sformatf("lo@%0d", e.due), E_LO, e.lo);
    end
  end

  initial begin
    int guard;
    reset = 1'b1; E_MDUOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
    model_clear();
    #1;
    chk("reset_busy", 32'(E_Busy), 32'd0);
    chk("reset_hi", E_HI, 32'd0);
    chk("reset_lo", E_LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // signed and unsigned multiply of the same operands
    step(4'd1, 32'hFFFF_FFFE, 32'd3);
    repeat (MC) step(4'd0, rnd_val(), rnd_val());
    chk("mult_hi", E_HI, 32'hFFFF_FFFF);
    chk("mult_lo", E_LO, 32'hFFFF_FFFA);
    step(4'd2, 32'hFFFF_FFFE, 32'd3);
    repeat (MC) step(4'd0, rnd_val(), rnd_val());
    chk("multu_hi", E_HI, 32'h0000_0002);
    chk("multu_lo", E_LO, 32'hFFFF_FFFA);

    // signed divide, divide by zero, overflow case
    step(4'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (DC) step(4'd0, rnd_val(), rnd_val());
    chk("div_hi", E_HI, 32'hFFFF_FFFF);
    chk("div_lo", E_LO, 32'hFFFF_FFFD);
    step(4'd4, 32'd7, 32'd0);
    repeat (DC) step(4'd0, rnd_val(), rnd_val());
    chk("divz_hi", E_HI, 32'hFFFF_FFFF);
    chk("divz_lo", E_LO, 32'hFFFF_FFFD);
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DC) step(4'd0, rnd_val(), rnd_val());
    chk("divovf_hi", E_HI, 32'h0000_0000);
    chk("divovf_lo", E_LO, 32'h8000_0000);

    // mthi single cycle; mtlo while busy is dropped
    step(4'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", E_HI, 32'h1234_5678);
    chk("mthi_busy", 32'(E_Busy), 32'd0);
    step(4'd1, 32'd2, 32'd3);
    step(4'd6, 32'h0000_DEAD, 32'd0);
    repeat (MC - 1) step(4'd0, 32'd0, 32'd0);
    chk("mtlo_busy_hi", E_HI, 32'd0);
    chk("mtlo_busy_lo", E_LO, 32'd6);

    // reset three cycles into a mult, then make sure nothing lands late
    step(4'd1, 32'd5, 32'd7);
    repeat (2) step(4'd0, 32'd0, 32'd0);
    pulse_reset();
    repeat (MC + 2) step(4'd0, 32'd0, 32'd0);
    chk("post_rst_hi", E_HI, 32'd0);
    chk("post_rst_lo", E_LO, 32'd0);

    // accumulate (or no-op without the feature)
    step(4'd5, 32'd0, 32'd0);
    step(4'd6, 32'hFFFF_FFFF, 32'd0);
    step(4'd7, 32'd1, 32'd1);
    repeat (MC) step(4'd0, 32'd0, 32'd0);
    chk("madd_hi", E_HI, MADD_ON ? 32'd1 : 32'd0);
    chk("madd_lo", E_LO, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

    // randomized traffic, including ops that collide with a busy unit
    repeat (1500) step(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
    repeat (DC + 2) step(4'd0, 32'd0, 32'd0);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
